// File: rtl/alu_issue.sv
// Command sequencer for the 16-bit rotate/SLT ALU: it encodes the opcode, drives the ALU from registers and returns the tagged result.
// Define SELFCHECK_EN to add an inverse-rotate CHECK pass that reports mismatches on rsp_err.
`timescale 1ns/1ps

module alu_issue #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [4:0]       cmd_amt,
    input  logic [15:0]      cmd_a,
    input  logic [15:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [15:0]      alu_inp0,
    output logic [15:0]      alu_inp1,
    output logic [0:5]       alu_opcode,
    input  logic [15:0]      alu_opt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_RESP
`ifdef SELFCHECK_EN
        , S_CHECK
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [15:0]        data_q, data_d;
    logic [15:0]        inp0_q, inp0_d;
    logic [15:0]        inp1_q, inp1_d;
    logic [0:5]         opcode_q, opcode_d;
`ifdef SELFCHECK_EN
    logic [15:0]        a_q, a_d;
    logic               err_q, err_d;
`endif

    // Opcode encoding of the incoming command. A rotate by -16 wraps to an
    // identity, so the direction bit is only set for a non-zero magnitude.
    logic [4:0] neg_amt;
    logic [3:0] cmd_mag;
    logic       cmd_right;
    logic [0:5] cmd_opcode;

    always_comb begin
        neg_amt    = 5'(-cmd_amt);
        cmd_mag    = cmd_amt[4] ? neg_amt[3:0] : cmd_amt[3:0];
        cmd_right  = cmd_amt[4] && (cmd_mag != 4'd0);
        cmd_opcode = cmd_op ? 6'b100000 : {1'b0, cmd_right, cmd_mag};
    end

    // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        tag_d    = tag_q;
        data_d   = data_q;
        inp0_d   = inp0_q;
        inp1_d   = inp1_q;
        opcode_d = opcode_q;
`ifdef SELFCHECK_EN
        a_d      = a_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    tag_d    = cmd_tag;
                    inp0_d   = cmd_a;
                    inp1_d   = cmd_op ? cmd_b : 16'h0000;
                    opcode_d = cmd_opcode;
`ifdef SELFCHECK_EN
                    a_d      = cmd_a;
                    err_d    = 1'b0;
`endif
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                data_d  = alu_opt;
                state_d = S_RESP;
`ifdef SELFCHECK_EN
                // Feed the forward result back with the direction flipped; it must reproduce A.
                if (!opcode_q[0]) begin
                    inp0_d      = alu_opt;
                    opcode_d[1] = ~opcode_q[1];
                    state_d     = S_CHECK;
                end
`endif
            end
`ifdef SELFCHECK_EN
            S_CHECK: begin
                err_d   = (alu_opt != a_q);
                state_d = S_RESP;
            end
`endif
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tag_q    <= '0;
            data_q   <= '0;
            inp0_q   <= '0;
            inp1_q   <= '0;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            inp0_q   <= inp0_d;
            inp1_q   <= inp1_d;
            opcode_q <= opcode_d;
        end
    end

`ifdef SELFCHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            err_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            err_q <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_data   = data_q;
    assign rsp_tag    = tag_q;
    assign alu_inp0   = inp0_q;
    assign alu_inp1   = inp1_q;
    assign alu_opcode = opcode_q;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized self-checking bench for alu_issue with a behavioural ALU, optionally faulty on right rotates.
`timescale 1ns/1ps

module tb_alu_issue;

`ifdef SELFCHECK_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_op = 1'b0;
    logic [4:0]  cmd_amt = '0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic [3:0]  cmd_tag = '0;
    logic [15:0] alu_inp0;
    logic [15:0] alu_inp1;
    logic [0:5]  alu_opcode;
    logic [15:0] alu_opt;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    bit          fault_right = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_issue #(.TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_amt(cmd_amt),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_inp0(alu_inp0), .alu_inp1(alu_inp1), .alu_opcode(alu_opcode), .alu_opt(alu_opt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    function automatic logic [15:0] rotl(input logic [15:0] v, input int k);
        logic [31:0] w;
        w = {v, v} << k;
        return w[31:16];
    endfunction

    // Bench ALU: decodes the opcode the way the ALU does; optional fault flips bit 0 on right rotates.
    function automatic logic [15:0] bench_alu(input logic [15:0] i0, input logic [15:0] i1,
                                              input logic [0:5] op, input bit fault);
        int mag;
        logic [15:0] r;
        if (op[0]) return {15'b0, ($signed(i0) < $signed(i1))};
        mag = int'(op[2:5]);
        r = rotl(i0, op[1] ? (16 - mag) % 16 : mag);
        if (op[1] && fault) r = r ^ 16'h0001;
        return r;
    endfunction

    assign alu_opt = bench_alu(alu_inp0, alu_inp1, alu_opcode, fault_right);

    // Reference model, straight from the command semantics.
    function automatic logic [15:0] exp_result(input bit op, input int amt,
                                               input logic [15:0] a, input logic [15:0] b);
        if (op) return {15'b0, ($signed(a) < $signed(b))};
        return rotl(a, (amt + 16) % 16);
    endfunction

    function automatic logic [5:0] exp_opcode(input bit op, input int amt);
        if (op) return 6'b100000;
        if (amt == 0 || amt == -16) return 6'b000000;
        if (amt > 0) return {2'b00, 4'(amt)};
        return {2'b01, 4'(-amt)};
    endfunction

    // One command through the block; called at #1 after a rising edge with the DUT idle.
    task automatic run_cmd(input bit op, input int amt, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] tag, input int hold, input bit exp_err);
        logic [15:0] er;
        logic [5:0]  eo;
        logic [5:0]  eo_hold;
        logic [15:0] i0_hold;
        bit          chk;
        er = exp_result(op, amt, a, b);
        eo = exp_opcode(op, amt);
        chk = SC && !op;
        eo_hold = chk ? (eo ^ 6'b010000) : eo;
        i0_hold = chk ? er : a;

        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", cmd_ready); else n_pass++;
        cmd_valid = 1'b1; cmd_op = op; cmd_amt = 5'(amt); cmd_a = a; cmd_b = b; cmd_tag = tag;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_a = 16'($urandom); cmd_b = 16'($urandom); cmd_tag = 4'($urandom);
        cmd_op = 1'($urandom); cmd_amt = 5'($urandom);
        n_checks++; if (alu_opcode !== eo) $display("FAIL opcode op=%0d amt=%0d: got %b want %b", op, amt, alu_opcode, eo); else n_pass++;
        n_checks++; if (alu_inp0 !== a) $display("FAIL inp0: got %h want %h", alu_inp0, a); else n_pass++;
        n_checks++; if (alu_inp1 !== (op ? b : 16'h0000)) $display("FAIL inp1: got %h want %h", alu_inp1, op ? b : 16'h0000); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) $display("FAIL drive_flags: valid=%b ready=%b want 0 0", rsp_valid, cmd_ready); else n_pass++;
        @(posedge clk); #1;
        if (chk) begin
            n_checks++; if (rsp_valid !== 1'b0) $display("FAIL check_valid: got %b want 0", rsp_valid); else n_pass++;
            n_checks++; if (alu_opcode !== eo_hold) $display("FAIL inv_opcode: got %b want %b", alu_opcode, eo_hold); else n_pass++;
            n_checks++; if (alu_inp0 !== er) $display("FAIL inv_inp0: got %h want %h", alu_inp0, er); else n_pass++;
            @(posedge clk); #1;
        end
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL rsp_latency: valid=%b want 1", rsp_valid); else n_pass++;
        n_checks++; if (rsp_data !== er) $display("FAIL rsp_data op=%0d amt=%0d a=%h b=%h: got %h want %h", op, amt, a, b, rsp_data, er); else n_pass++;
        n_checks++; if (rsp_tag !== tag) $display("FAIL rsp_tag: got %h want %h", rsp_tag, tag); else n_pass++;
        n_checks++; if (rsp_err !== exp_err) $display("FAIL rsp_err: got %b want %b", rsp_err, exp_err); else n_pass++;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== er || rsp_tag !== tag || rsp_err !== exp_err || cmd_ready !== 1'b0)
                $display("FAIL hold%0d: valid=%b data=%h tag=%h err=%b ready=%b want 1 %h %h %b 0",
                         i, rsp_valid, rsp_data, rsp_tag, rsp_err, cmd_ready, er, tag, exp_err);
            else n_pass++;
            n_checks++;
            if (alu_opcode !== eo_hold || alu_inp0 !== i0_hold)
                $display("FAIL alu_hold%0d: opcode=%b inp0=%h want %b %h", i, alu_opcode, alu_inp0, eo_hold, i0_hold);
            else n_pass++;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL after_accept: valid=%b ready=%b want 0 1", rsp_valid, cmd_ready); else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) $display("FAIL reset_flags: valid=%b err=%b want 0 0", rsp_valid, rsp_err); else n_pass++;
        n_checks++; if (rsp_data !== 16'h0 || rsp_tag !== 4'h0) $display("FAIL reset_rsp: data=%h tag=%h want 0 0", rsp_data, rsp_tag); else n_pass++;
        n_checks++; if (alu_inp0 !== 16'h0 || alu_inp1 !== 16'h0) $display("FAIL reset_inp: %h %h want 0 0", alu_inp0, alu_inp1); else n_pass++;
        n_checks++; if (alu_opcode !== 6'b000000) $display("FAIL reset_opcode: got %b want 000000", alu_opcode); else n_pass++;
    endtask

    task automatic test_rotate();
        run_cmd(1'b0, 4, 16'h1234, 16'h0, 4'h5, 0, 1'b0);
        run_cmd(1'b0, -1, 16'h0001, 16'hFFFF, 4'hA, 0, 1'b0);
        run_cmd(1'b0, -16, 16'hBEEF, 16'h0, 4'h3, 0, 1'b0);
        run_cmd(1'b0, 0, 16'hBEEF, 16'h0, 4'hC, 0, 1'b0);
        run_cmd(1'b0, 15, 16'h8001, 16'h0, 4'h1, 0, 1'b0);
        run_cmd(1'b0, -15, 16'h8001, 16'h0, 4'h2, 0, 1'b0);
    endtask

    task automatic test_slt();
        run_cmd(1'b1, 0, 16'h0003, 16'h0005, 4'h7, 0, 1'b0);
        run_cmd(1'b1, -9, 16'h0005, 16'h0003, 4'h8, 0, 1'b0);
        run_cmd(1'b1, 2, 16'h1111, 16'h1111, 4'h9, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_cmd(1'b0, 7, 16'hA5C3, 16'h0, 4'hE, 5, 1'b0);
        run_cmd(1'b1, 0, 16'h0010, 16'h0020, 4'hF, 5, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_cmd(1'($urandom), int'($urandom_range(31)) - 16, 16'($urandom), 16'($urandom),
                    4'($urandom), int'($urandom_range(3)), 1'b0);
        end
    endtask

    // SLT stream with cmd_valid and rsp_ready held high: one accept every 3 cycles.
    task automatic test_back_to_back();
        int prev = -1;
        int accepts = 0;
        logic [15:0] la = '0, lb = '0;
        logic [3:0]  lt = '0;
        rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_op = 1'b1;
        cmd_a = 16'($urandom); cmd_b = 16'($urandom); cmd_tag = 4'($urandom);
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (rsp_valid) begin
                n_checks++; if (cyc - prev != 2) $display("FAIL b2b_latency: %0d want 2", cyc - prev); else n_pass++;
                n_checks++; if (rsp_data !== exp_result(1'b1, 0, la, lb) || rsp_tag !== lt)
                    $display("FAIL b2b_rsp: data=%h tag=%h want %h %h", rsp_data, rsp_tag, exp_result(1'b1, 0, la, lb), lt);
                else n_pass++;
            end
            if (cmd_ready) begin
                if (prev >= 0) begin
                    n_checks++; if (cyc - prev != 3) $display("FAIL b2b_gap: %0d want 3", cyc - prev); else n_pass++;
                end
                prev = cyc; accepts++; la = cmd_a; lb = cmd_b; lt = cmd_tag;
            end else begin
                cmd_a = 16'($urandom); cmd_b = 16'($urandom); cmd_tag = 4'($urandom);
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        n_checks++; if (accepts < 4) $display("FAIL b2b_accepts: got %0d want >=4", accepts); else n_pass++;
        for (int i = 0; i < 6 && !cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL b2b_drain: ready=%b want 1", cmd_ready); else n_pass++;
    endtask

    task automatic test_selfcheck_fault();
        fault_right = 1'b1;
        run_cmd(1'b0, 3, 16'h00F0, 16'h0, 4'h6, 2, SC);
        fault_right = 1'b0;
        run_cmd(1'b0, 3, 16'h00F0, 16'h0, 4'h4, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_amt = 5'd5; cmd_a = 16'h1357; cmd_tag = 4'hD;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL async_reset: valid=%b ready=%b want 0 1", rsp_valid, cmd_ready); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (seen) $display("FAIL dropped_cmd: rsp_valid rose after reset, want never"); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", cmd_ready); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_slt();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_selfcheck_fault();
        test_reset_mid();
        run_cmd(1'b0, -6, 16'hC0DE, 16'h0, 4'hB, 1, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
